nn_param_update_scheduler: RTL and testbench

Sequencer that owns write access to a bank of `N_PARAM` latched parameter registers (weights/biases with sign-magnitude value and resistance). It accepts parameter-update requests over a valid/ready handshake and reads the target parameter's current state. It computes the saturated sign-magnitude update, scaled by that parameter's resistance, and drives the shared `MODIFIER`/`SIGN_MODIFIER`/`RESISTANCE_NEW` bus. It then issues a clean one-hot `TRIG` pulse to the target register, so exactly one latched register updates per request with setup-stable data.

---
 rtl/nn_param_update_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_nn_param_update_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_param_update_scheduler.sv
// Update sequencer for a bank of latched parameter registers: a request is captured,
// the saturated sign-magnitude update is computed, then one clean TRIG pulse is issued.
module nn_param_update_scheduler #(
  parameter int N            = 8,
  parameter int N_RESISTANCE = 8,
  parameter int N_PARAM      = 4,
  parameter int IDX_W        = 2
) (
  input  logic                        CLK,
  input  logic                        INIT,
  input  logic                        FREEZE,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic [IDX_W-1:0]            REQ_IDX,
  input  logic [N-1:0]                REQ_DELTA,
  input  logic                        REQ_SIGN,
  input  logic [N_RESISTANCE-1:0]     REQ_RES_STEP,
  input  logic [N_PARAM*N-1:0]        PARAM_VALUE,
  input  logic [N_PARAM-1:0]          PARAM_SIGN,
  input  logic [N_PARAM*N_RESISTANCE-1:0] PARAM_RES,
  output logic [N-1:0]                MODIFIER,
  output logic                        SIGN_MODIFIER,
  output logic [N_RESISTANCE-1:0]     RESISTANCE_NEW,
  output logic [N_PARAM-1:0]          TRIG,
  output logic                        DONE,
  output logic                        SAT,
  output logic                        ERR,
  output logic [2:0]                  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_COMPUTE = 3'd2,
    S_PULSE   = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [N-1:0]              r_delta;
  logic                      r_sign;
  logic [N_RESISTANCE-1:0]   r_step;
  logic [N-1:0]              r_cur_val;
  logic                      r_cur_sign;
  logic [N_RESISTANCE-1:0]   r_cur_res;
  logic [N-1:0]              r_modifier;
  logic                      r_sign_mod;
  logic [N_RESISTANCE-1:0]   r_res_new;
  logic [N_PARAM-1:0]        r_trig;
  logic                      r_done;
  logic                      r_sat;
  logic                      r_err;

  logic [N-1:0]              w_sel_val;
  logic                      w_sel_sign;
  logic [N_RESISTANCE-1:0]   w_sel_res;
  logic [N_PARAM-1:0]        w_onehot;
  logic                      w_idx_ok;
  logic [N-1:0]              w_eff;
  logic [N:0]                w_sum;
  logic [N_RESISTANCE:0]     w_res_sum;
  logic [N-1:0]              w_mag;
  logic                      w_nsign;
  logic                      w_sat;

  // Handshake: a request transfers on a rising edge where REQ_VALID and REQ_READY are both high;
  // the requester holds its fields stable until then, and READY never depends on VALID.
  assign REQ_READY = (r_state == S_IDLE) & ~FREEZE & ~INIT;

  always_comb begin
    w_sel_val  = '0;
    w_sel_sign = 1'b0;
    w_sel_res  = '0;
    w_onehot   = '0;
    for (int k = 0; k < N_PARAM; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_val   = PARAM_VALUE[k*N +: N];
        w_sel_sign  = PARAM_SIGN[k];
        w_sel_res   = PARAM_RES[k*N_RESISTANCE +: N_RESISTANCE];
        w_onehot[k] = 1'b1;
      end
    end
    w_idx_ok = (int'(r_idx) < N_PARAM);
  end

  // Resistance acts as a right shift of the delta; shifting by N or more leaves nothing.
  assign w_eff     = (r_cur_res >= N_RESISTANCE'(N)) ? '0 : (r_delta >> r_cur_res);
  assign w_sum     = {1'b0, r_cur_val} + {1'b0, w_eff};
  assign w_res_sum = {1'b0, r_cur_res} + {1'b0, r_step};

  always_comb begin
    w_mag   = r_cur_val;
    w_nsign = r_cur_sign;
    w_sat   = 1'b0;
    if (r_sign == r_cur_sign) begin
      if (w_sum[N]) begin
        w_mag = '1;
        w_sat = 1'b1;
      end else begin
        w_mag = w_sum[N-1:0];
      end
    end else if (w_eff > r_cur_val) begin
      w_mag   = w_eff - r_cur_val;
      w_nsign = r_sign;
    end else if (w_eff == r_cur_val) begin
      w_mag   = '0;
      w_nsign = 1'b0;
    end else begin
      w_mag = r_cur_val - w_eff;
    end
    if (w_mag == '0) w_nsign = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_delta    <= '0;
      r_sign     <= 1'b0;
      r_step     <= '0;
      r_cur_val  <= '0;
      r_cur_sign <= 1'b0;
      r_cur_res  <= '0;
      r_modifier <= '0;
      r_sign_mod <= 1'b0;
      r_res_new  <= '0;
      r_trig     <= '0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_trig <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            r_idx   <= REQ_IDX;
            r_delta <= REQ_DELTA;
            r_sign  <= REQ_SIGN;
            r_step  <= REQ_RES_STEP;
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!w_idx_ok) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cur_val  <= w_sel_val;
            r_cur_sign <= w_sel_sign;
            r_cur_res  <= w_sel_res;
            r_state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_modifier <= w_mag;
          r_sign_mod <= w_nsign;
          r_sat      <= w_sat;
          r_res_new  <= w_res_sum[N_RESISTANCE] ? '1 : w_res_sum[N_RESISTANCE-1:0];
          r_state    <= S_PULSE;
        end
        S_PULSE: begin
          // Bus has been stable a full cycle; strobe rises on the next edge.
          r_trig  <= w_onehot;
          r_state <= S_RECOVER;
        end
        S_RECOVER: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MODIFIER       = r_modifier;
  assign SIGN_MODIFIER  = r_sign_mod;
  assign RESISTANCE_NEW = r_res_new;
  assign TRIG           = r_trig;
  assign DONE           = r_done;
  assign SAT            = r_sat;
  assign ERR            = r_err;
  assign DBG_STATE      = r_state;

endmodule

// File: tb/tb_nn_param_update_scheduler.sv
// Directed bench for nn_param_update_scheduler: requests push expected completions,
// a negedge monitor pops and checks bus, strobe, flags and latency.
module tb_nn_param_update_scheduler;
  localparam int N  = 8;
  localparam int NR = 8;
  localparam int NP = 3;
  localparam int IW = 2;

  logic CLK = 1'b0;
  logic INIT, FREEZE, REQ_VALID, REQ_READY, REQ_SIGN;
  logic [IW-1:0]    REQ_IDX;
  logic [N-1:0]     REQ_DELTA;
  logic [NR-1:0]    REQ_RES_STEP;
  logic [NP*N-1:0]  PARAM_VALUE;
  logic [NP-1:0]    PARAM_SIGN;
  logic [NP*NR-1:0] PARAM_RES;
  logic [N-1:0]     MODIFIER;
  logic             SIGN_MODIFIER;
  logic [NR-1:0]    RESISTANCE_NEW;
  logic [NP-1:0]    TRIG;
  logic             DONE, SAT, ERR;
  logic [2:0]       DBG_STATE;

  nn_param_update_scheduler #(.N(N), .N_RESISTANCE(NR), .N_PARAM(NP), .IDX_W(IW)) dut (
    .CLK(CLK), .INIT(INIT), .FREEZE(FREEZE), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_IDX(REQ_IDX), .REQ_DELTA(REQ_DELTA), .REQ_SIGN(REQ_SIGN), .REQ_RES_STEP(REQ_RES_STEP),
    .PARAM_VALUE(PARAM_VALUE), .PARAM_SIGN(PARAM_SIGN), .PARAM_RES(PARAM_RES),
    .MODIFIER(MODIFIER), .SIGN_MODIFIER(SIGN_MODIFIER), .RESISTANCE_NEW(RESISTANCE_NEW),
    .TRIG(TRIG), .DONE(DONE), .SAT(SAT), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_err;
    logic [1:0]  idx;
    logic [7:0]  mod;
    logic        sgn;
    logic [7:0]  res;
    logic        sat;
    logic [31:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_done(input int acc, input int idx, input int mod, input int sgn,
                          input int res, input int sat);
    exp_t e;
    if (acc < 0) return;
    e.is_err = 1'b0; e.idx = 2'(idx); e.mod = 8'(mod); e.sgn = 1'(sgn);
    e.res = 8'(res); e.sat = 1'(sat); e.acc = 32'(acc);
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input int acc);
    exp_t e;
    if (acc < 0) return;
    e = '0;
    e.is_err = 1'b1; e.acc = 32'(acc);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic [NP-1:0] prev_trig = '0;
  logic [N-1:0]  prev_mod  = '0;
  logic [N-1:0]  prev2_mod = '0;

  always @(negedge CLK) begin
    exp_t e;
    if (TRIG != '0) chk("trig_onehot", $countones(TRIG), 1);
    if (DONE || ERR) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: DONE=%0b ERR=%0b with nothing outstanding (cycle %0d)",
                 DONE, ERR, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("kind_err", ERR, e.is_err);
        chk("kind_done", DONE, !e.is_err);
        chk("latency", cyc - int'(e.acc), e.is_err ? 1 : 4);
        chk("trig_low_now", TRIG, 0);
        if (e.is_err) begin
          chk("err_no_trig", prev_trig, 0);
        end else begin
          chk("modifier", MODIFIER, e.mod);
          chk("sign_modifier", SIGN_MODIFIER, e.sgn);
          chk("resistance_new", RESISTANCE_NEW, e.res);
          chk("sat", SAT, e.sat);
          chk("trig_slot", prev_trig, 32'(1) << e.idx);
          chk("mod_during_trig", prev_mod, e.mod);
          chk("mod_before_trig", prev2_mod, e.mod);
        end
      end
    end
    prev_trig = TRIG;
    prev2_mod = prev_mod;
    prev_mod  = MODIFIER;
  end

  // ---------------- driver tasks ----------------
  task automatic set_param(input int k, input int val, input int sgn, input int res);
    PARAM_VALUE[k*N +: N]  = 8'(val);
    PARAM_SIGN[k]          = 1'(sgn);
    PARAM_RES[k*NR +: NR]  = 8'(res);
  endtask

  task automatic send(input int idx, input int d, input int s, input int step, output int acc);
    REQ_IDX      = IW'(idx);
    REQ_DELTA    = 8'(d);
    REQ_SIGN     = 1'(s);
    REQ_RES_STEP = 8'(step);
    REQ_VALID    = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin
        acc = cyc + 1;
        @(posedge CLK);
        break;
      end
    end
    #1 REQ_VALID = 1'b0;
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: request idx %0d not accepted within 40 cycles", idx);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d completions outstanding, 0 required", exp_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2;
    logic seen_ready;
    INIT = 1'b1; FREEZE = 1'b0; REQ_VALID = 1'b0; REQ_IDX = '0; REQ_DELTA = '0;
    REQ_SIGN = 1'b0; REQ_RES_STEP = '0; PARAM_VALUE = '0; PARAM_SIGN = '0; PARAM_RES = '0;
    repeat (2) @(posedge CLK);
    #1 REQ_VALID = 1'b1; REQ_IDX = 2'd1;
    #1 chk("ready_in_init", REQ_READY, 0);
    @(posedge CLK);
    #1;
    chk("rst_state", DBG_STATE, 0);
    chk("rst_trig", TRIG, 0);
    chk("rst_modifier", MODIFIER, 0);
    chk("rst_res", RESISTANCE_NEW, 0);
    chk("rst_flags", {DONE, SAT, ERR, SIGN_MODIFIER}, 0);
    REQ_VALID = 1'b0;
    INIT = 1'b0;
    #1 chk("ready_after_init", REQ_READY, 1);

    // nominal; param changed right after capture must not matter
    set_param(2, 100, 0, 1);
    send(2, 40, 0, 1, a1); exp_done(a1, 2, 120, 0, 2, 0);
    @(posedge CLK); #1 set_param(2, 5, 1, 200);
    drain();

    // saturation
    set_param(0, 250, 1, 0);
    send(0, 10, 1, 0, a1); exp_done(a1, 0, 255, 1, 0, 1);
    drain();

    // sign crossing then exact cancel
    set_param(1, 30, 0, 0);
    send(1, 50, 1, 0, a1); exp_done(a1, 1, 20, 1, 0, 0);
    drain();
    send(1, 30, 1, 0, a1); exp_done(a1, 1, 0, 0, 0, 0);
    drain();

    // resistance limits
    set_param(1, 77, 1, 8);
    send(1, 200, 0, 0, a1); exp_done(a1, 1, 77, 1, 8, 0);
    drain();
    set_param(2, 10, 0, 253);
    send(2, 100, 0, 5, a1); exp_done(a1, 2, 10, 0, 255, 0);
    drain();

    // out-of-range index, then the next request is accepted two edges later
    set_param(2, 100, 0, 1);
    send(3, 9, 0, 1, a1); exp_err(a1);
    send(2, 40, 0, 1, a2); exp_done(a2, 2, 120, 0, 2, 0);
    chk("err_ready_gap", a2 - a1, 2);
    drain();

    // back-to-back with valid held: five edges apart
    set_param(0, 200, 0, 2);
    send(0, 100, 1, 3, a1); exp_done(a1, 0, 175, 0, 5, 0);
    send(0, 100, 1, 3, a2); exp_done(a2, 0, 175, 0, 5, 0);
    chk("b2b_gap", a2 - a1, 5);
    drain();

    // FREEZE raised mid-request: ready stays low, request still completes
    send(2, 40, 0, 1, a1); exp_done(a1, 2, 120, 0, 2, 0);
    FREEZE = 1'b1;
    seen_ready = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (REQ_READY) seen_ready = 1'b1;
    end
    chk("freeze_ready", seen_ready, 0);
    chk("freeze_outstanding", exp_q.size(), 0);
    FREEZE = 1'b0;
    #1 chk("unfreeze_ready", REQ_READY, 1);
    drain();

    // INIT while TRIG is high: strobe drops, no DONE, everything cleared
    set_param(1, 60, 0, 0);
    send(1, 7, 0, 1, a1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (TRIG != '0) break;
    end
    chk("trig_before_init", TRIG, 3'b010);
    chk("mod_before_init", MODIFIER, 67);
    INIT = 1'b1;
    @(posedge CLK);
    #1;
    chk("init_trig", TRIG, 0);
    chk("init_done", DONE, 0);
    chk("init_modifier", MODIFIER, 0);
    chk("init_res", RESISTANCE_NEW, 0);
    chk("init_state", DBG_STATE, 0);
    chk("init_ready", REQ_READY, 0);
    @(negedge CLK);
    INIT = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    send(1, 7, 0, 1, a1); exp_done(a1, 1, 67, 0, 1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
